// File: rtl/scan_ctrl.sv
// scan_ctrl: sequences an external 14-bit address counter through one frame
// (0..LAST_ADDR), offering each address downstream with a req/rdy handshake.
// The counter itself lives outside; this block only steers it with clear/keep.
//
// Optional feature: define SCAN_CTRL_PAUSE_EN to add a 'pause' input that
// stalls the scan (req=0, counter held) while keeping busy asserted.
module scan_ctrl #(
  parameter int LAST_ADDR = 16383,  // final address of a frame, 1..16383
  parameter int ROW_LEN   = 128     // pixels per row, power of two, 2..8192
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SCAN_CTRL_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        start,
  input  logic [13:0] count,
  input  logic        rdy,
  output logic        clear,
  output logic        keep,
  output logic        req,
  output logic [13:0] addr,
  output logic        row_end,
  output logic        busy,
  output logic        done
);

  // State encoding kept as plain constants so older tooling can read it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [13:0] LAST     = 14'(LAST_ADDR);
  localparam logic [13:0] ROW_MASK = 14'(ROW_LEN - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // A stall blocks the transfer even when downstream is ready.
  logic stall;
`ifdef SCAN_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  logic xfer;
  logic last_pix;
  assign xfer     = (state_q == RUN) && rdy && !stall;
  assign last_pix = (count & ROW_MASK) == ROW_MASK;

  // Next-state logic: start only matters in IDLE; DONE always falls back to IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (xfer && (count == LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any scan immediately and without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Output decode: combinational from state, count and rdy (and pause when built in).
  always_comb begin
    clear   = 1'b1;
    keep    = 1'b0;
    req     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    row_end = 1'b0;
    addr    = count;
    case (state_q)
      RUN: begin
        clear   = 1'b0;
        busy    = 1'b1;
        req     = !stall;
        keep    = stall || !rdy;
        row_end = !stall && last_pix;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
